// File: rtl/seg7_result_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_result_display_pkg
// Description : Shared types and constants for the result display block:
//               converter state encoding, digit count, segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_result_display_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal digit patterns, element N is the pattern for digit N
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Non-decimal nibbles never reach the decoder in practice; show nothing
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    if (d <= 4'd9) begin
      return SEG_TABLE[d];
    end
    return SEG_BLANK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Free-running iterative 16-bit binary to BCD converter
//               (shift-add-3). One sample every 18 cycles; holds the low four
//               BCD digits and an over-9999 flag of the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import seg7_result_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_i,
  output logic [15:0] bcd_o,
  output logic        ovf_o,
  output logic        done_o
);

  conv_state_e state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [19:0] acc_q, acc_d;     // five nibbles so 65535 fits without loss
  logic [3:0]  iter_q, iter_d;
  logic        cand_q, cand_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [19:0] adj;
  logic [35:0] shifted;

  // Converter state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      cand_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      cand_q  <= cand_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: snapshot, 16 add-3-then-shift steps, publish
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    cand_d  = cand_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    adj     = acc_q;
    for (int k = 0; k < 5; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    shifted = {adj, shreg_q} << 1;

    case (state_q)
      ST_IDLE: begin
        shreg_d = value_i;
        acc_d   = '0;
        cand_d  = (value_i > 16'd9999);
        iter_d  = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d   = shifted[35:16];
        shreg_d = shifted[15:0];
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = acc_q[15:0];
        ovf_d   = cand_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
  assign done_o = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/seg7_result_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_result_display
// Description : Shows the solver result on a 4-digit multiplexed common-anode
//               seven-segment display with leading-zero blanking and a dash
//               pattern when the value exceeds four digits.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_result_display
  import seg7_result_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [15:0]           bcd_out,
  output logic                  bcd_valid,
  output logic                  ovf
);

  localparam int                CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            idx_q;
  logic                  valid_q;
  logic                  conv_done;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            digit;
  logic                  upper_zero;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .value_i (value),
    .bcd_o   (bcd_out),
    .ovf_o   (ovf),
    .done_o  (conv_done)
  );

  // Digit slot timer and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sticky flag: a conversion has completed since reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (conv_done) begin
      valid_q <= 1'b1;
    end
  end

  // Anode select and segment pattern for the current digit slot
  always_comb begin
    digit      = bcd_out[{idx_q, 2'b00} +: 4];
    upper_zero = ((bcd_out >> {idx_q, 2'b00}) == 16'd0);
    an_d       = ~(NUM_DIGITS'(1) << idx_q);
    seg_d      = SEG_BLANK;
    if (!valid_q) begin
      seg_d = SEG_BLANK;
    end else if (ovf) begin
      seg_d = SEG_DASH;
    end else if (BLANK_LZ && (idx_q != 2'd0) && upper_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_digit(digit);
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign bcd_valid = valid_q;

endmodule
`default_nettype wire
